// File: rtl/timing_io.sv
// 4004 instruction-cycle timing: 16 sysclk per cycle (8 subcycles x 2 phases), registered strobes/SYNC/command/POC.
// All outputs are flops decoding the next state, so they track subcycle/phase; optional HALT state under CYCLE_STOP_EN.
module timing_io (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       io_op,
`ifdef CYCLE_STOP_EN
  input  logic       stop,
  output logic       stop_ack,
`endif
  output logic       a12,
  output logic       a22,
  output logic       a32,
  output logic       m12,
  output logic       m22,
  output logic       x12,
  output logic       x22,
  output logic       x32,
  output logic       x21_clk2,
  output logic       x31_clk2,
  output logic       sync_n,
  output logic       com_n,
  output logic       poc,
  output logic [2:0] subcycle,
  output logic       phase
);

  localparam logic [2:0] SC_A1 = 3'd0;
  localparam logic [2:0] SC_A3 = 3'd2;
  localparam logic [2:0] SC_M1 = 3'd3;
  localparam logic [2:0] SC_M2 = 3'd4;
  localparam logic [2:0] SC_X2 = 3'd6;
  localparam logic [2:0] SC_X3 = 3'd7;

  logic [2:0] sub_q, sub_d;
  logic       ph_q, ph_d;
  logic       io_q, io_d;
  logic [1:0] cnt_q, cnt_d;

`ifdef CYCLE_STOP_EN
  logic halt_q, halt_d;
  logic stop_ack_q, stop_ack_d;
`else
  logic halt_d;
  assign halt_d = 1'b0;
`endif

  logic [7:0] stb_q, stb_d;
  logic       x21_q, x21_d;
  logic       x31_q, x31_d;
  logic       sync_q, sync_d;
  logic       com_q, com_d;
  logic       poc_q, poc_d;

  // State and output registers
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      sub_q  <= SC_A1;
      ph_q   <= 1'b0;
      io_q   <= 1'b0;
      cnt_q  <= 2'd0;
      stb_q  <= 8'd0;
      x21_q  <= 1'b1;
      x31_q  <= 1'b1;
      sync_q <= 1'b1;
      com_q  <= 1'b1;
      poc_q  <= 1'b1;
`ifdef CYCLE_STOP_EN
      halt_q     <= 1'b0;
      stop_ack_q <= 1'b0;
`endif
    end else begin
      sub_q  <= sub_d;
      ph_q   <= ph_d;
      io_q   <= io_d;
      cnt_q  <= cnt_d;
      stb_q  <= stb_d;
      x21_q  <= x21_d;
      x31_q  <= x31_d;
      sync_q <= sync_d;
      com_q  <= com_d;
      poc_q  <= poc_d;
`ifdef CYCLE_STOP_EN
      halt_q     <= halt_d;
      stop_ack_q <= stop_ack_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    sub_d = sub_q;
    ph_d  = ph_q;
    io_d  = io_q;
    cnt_d = cnt_q;
`ifdef CYCLE_STOP_EN
    halt_d = halt_q;
    if (halt_q) begin
      if (!stop) begin
        halt_d = 1'b0;
        sub_d  = SC_A1;
        ph_d   = 1'b0;
      end
    end else
`endif
    if (!ph_q) begin
      ph_d = 1'b1;
    end else begin
      ph_d = 1'b0;
      if (sub_q == SC_X3) begin
        sub_d = SC_A1;
        io_d  = 1'b0;
        if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
`ifdef CYCLE_STOP_EN
        // HALT parks on (X3,1) so subcycle/phase hold while stopped
        if (stop) begin
          halt_d = 1'b1;
          sub_d  = SC_X3;
          ph_d   = 1'b1;
        end
`endif
      end else begin
        sub_d = sub_q + 3'd1;
        if (sub_q == SC_M1) io_d = io_op;
      end
    end
  end

  // Output decode of the next state, registered above
  always_comb begin
    stb_d = 8'd0;
    if (ph_d && !halt_d) stb_d[sub_d] = 1'b1;
    x21_d  = ~stb_d[SC_X2];
    x31_d  = ~stb_d[SC_X3];
    sync_d = ~((sub_d == SC_X3) && !halt_d);
    poc_d  = ~cnt_d[1];
    com_d  = poc_d | ~((sub_d == SC_A3) | ((sub_d == SC_M2) & io_d));
`ifdef CYCLE_STOP_EN
    stop_ack_d = halt_d;
`endif
  end

  assign a12      = stb_q[0];
  assign a22      = stb_q[1];
  assign a32      = stb_q[2];
  assign m12      = stb_q[3];
  assign m22      = stb_q[4];
  assign x12      = stb_q[5];
  assign x22      = stb_q[6];
  assign x32      = stb_q[7];
  assign x21_clk2 = x21_q;
  assign x31_clk2 = x31_q;
  assign sync_n   = sync_q;
  assign com_n    = com_q;
  assign poc      = poc_q;
  assign subcycle = sub_q;
  assign phase    = ph_q;
`ifdef CYCLE_STOP_EN
  assign stop_ack = stop_ack_q;
`endif

endmodule
